max_pool_2x2: RTL and testbench
===============================

# max_pool_2x2

Streaming 2×2, stride-2 max-pooling stage placed directly downstream of the ReLU activation in the convolution datapath. It consumes one activated feature-map pixel per handshake in raster order, keeps half a row of partial maxima in an internal line buffer, and emits one pooled pixel per 2×2 window through a registered valid/ready output. An optional compile-time ReLU clamp lets it take pre-activation data directly.

## Interface
- `IMG_W`, 28, input feature-map width in pixels; must be even and ≥ 2.
- `IMG_H`, 28, input feature-map height in pixels; must be even and ≥ 2.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_valid`  input  1  `in_data` holds a valid pixel.
- `in_ready`  output  1  block accepts a pixel this cycle.
- `in_data`  input  `INTERNAL_BITS` (32)  two's-complement pixel.
- `out_valid`  output  1  `out_data` holds a pooled pixel.
- `out_ready`  input  1  consumer accepts the pooled pixel.
- `out_data`  output  `INTERNAL_BITS`  pooled maximum, two's-complement.
- `out_last`  output  1  high alongside the final pooled pixel of a frame.

## Operation
- Beat: `in_valid && in_ready` on a rising edge; only beats advance counters.
- Counters: `col` covers 0..IMG_W-1 and `row` covers 0..IMG_H-1. `col` wraps to 0 and increments `row` after IMG_W-1. After pixel (IMG_H-1, IMG_W-1), both wrap to 0 and the next frame starts with no idle cycle.
- Row-phase FSM has two states:
  - `EVEN_ROW`: `row[0]`=0.
  - `ODD_ROW`: `row[0]`=1.
  - The transition fires on the beat where `col`=IMG_W-1. It is the only transition.
- Even column in either state: `hold` ← pixel.
- `EVEN_ROW`, odd column: `lbuf[col>>1]` ← max(`hold`, pixel). No output.
- `ODD_ROW`, odd column: the output register is loaded with max(`lbuf[col>>1]`, `hold`, pixel) and `out_valid` is set. `out_last` is set iff `row`=IMG_H-1 and `col`=IMG_W-1.
- Line buffer: IMG_W/2 entries of `INTERNAL_BITS`. Every entry is written in the even row before it is read, so the buffer needs no reset.
- Comparisons are signed 32-bit. Equal operands give that value. No width growth and no saturation.
- `in_ready` = !(`out_valid` && !`out_ready`). It is combinational from `out_ready` and stalls all input beats, including non-emitting ones, while output is blocked.
- Output register clears `out_valid`/`out_last` when `out_ready` is high and no new load occurs. Simultaneous drain and load replaces the contents and keeps `out_valid` high.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_last`=0.
  - `in_ready`=1.
  - `col`=`row`=0, FSM=`EVEN_ROW`, `hold`=0.
- Latency: `out_valid` rises on the clock edge that accepts the completing (odd-row, odd-col) beat, which is 1 cycle after that beat is presented.
- While `out_valid && !out_ready`, `out_data` and `out_last` hold stable and no input is accepted.
- Full throughput: one pixel per cycle when `out_ready` is held high.
- Reset asserted mid-frame: counters, FSM and output clear immediately. Any pending output is dropped. The next accepted beat is pixel (0,0) of a new frame.

## Configuration
- `POOL_RELU_CLAMP_EN`: when defined, each accepted pixel with bit 31 set is replaced by 0 before it is stored or compared, so outputs are always ≥ 0.
- When undefined, pixels pass unmodified and negative maxima propagate.

## Test plan
- IMG_W=IMG_H=4, pixels 1..16 raster, `out_ready`=1 → outputs 6, 8, 14, 16 in order; `out_last` only with 16; no input stalls.
- IMG_W=IMG_H=4, window values {0x7FFFFFFF, 0x80000000, −1, 0} in each window, macro off → each output 0x7FFFFFFF. Same frame with all pixels −5 → outputs −5 with macro off, 0 with macro on.
- 1..16 frame, `out_ready` low for 5 cycles after the first `out_valid` → `out_data`=6 stable, `in_ready`=0 throughout, no beat lost, full sequence still 6, 8, 14, 16.
- Two 4×4 frames back-to-back, second frame 101..116 → outputs 6, 8, 14, 16, 106, 108, 114, 116; `out_last` on 16 and 116.
- Reset pulsed after 6 beats of a frame, then a full 1..16 frame → `out_valid` drops asynchronously; outputs 6, 8, 14, 16 with no stale data.
- Random `in_valid`/`out_ready` gaps on a 28×28 frame → 196 outputs matching the reference model; `out_last` exactly once.

Source files
------------

// File: rtl/max_pool_2x2.sv
`timescale 1ns/1ps
// max_pool_2x2: streaming 2x2 / stride-2 max pooling over a raster-order
// feature map. A half-row line buffer holds the top-row pair maxima. One
// pooled pixel per window leaves through a registered valid/ready output.
// Optional build macro POOL_RELU_CLAMP_EN: negative input pixels are replaced
// by zero before they are stored or compared.
module max_pool_2x2 #(
   parameter int IMG_W         = 28,
   parameter int IMG_H         = 28,
   parameter int INTERNAL_BITS = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [INTERNAL_BITS-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [INTERNAL_BITS-1:0] out_data,
   output logic                     out_last
);

   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);
   localparam int LB_N  = IMG_W / 2;
   localparam int LB_W  = (LB_N > 1) ? $clog2(LB_N) : 1;

   typedef enum logic {
      EVEN_ROW = 1'b0,
      ODD_ROW  = 1'b1
   } phase_t;

   phase_t                   state;
   phase_t                   state_next;
   logic [COL_W-1:0]         col;
   logic [ROW_W-1:0]         row;
   logic [INTERNAL_BITS-1:0] hold;
   logic [INTERNAL_BITS-1:0] lbuf [LB_N];
   logic [INTERNAL_BITS-1:0] pix;
   logic [INTERNAL_BITS-1:0] pair_max;
   logic [INTERNAL_BITS-1:0] win_max;
   logic [LB_W-1:0]          lb_idx;
   logic                     beat;
   logic                     col_last;
   logic                     row_last;
   logic                     load;

   // Signed maximum; ties return the (identical) value.
   function automatic logic [INTERNAL_BITS-1:0] smax(
      input logic [INTERNAL_BITS-1:0] a,
      input logic [INTERNAL_BITS-1:0] b
   );
      return ($signed(a) >= $signed(b)) ? a : b;
   endfunction

   // Handshake: a transfer happens on a rising edge where valid && ready.
   // Input side stalls completely whenever a pooled pixel is waiting and the
   // consumer is not taking it, so no beat can overwrite pending state.
   assign in_ready = !(out_valid && !out_ready);
   assign beat     = in_valid && in_ready;

`ifdef POOL_RELU_CLAMP_EN
   assign pix = in_data[INTERNAL_BITS-1] ? '0 : in_data;
`else
   assign pix = in_data;
`endif

   assign col_last = (col == COL_W'(IMG_W - 1));
   assign row_last = (row == ROW_W'(IMG_H - 1));
   assign lb_idx   = LB_W'(col >> 1);
   assign pair_max = smax(hold, pix);
   assign win_max  = smax(lbuf[lb_idx], pair_max);
   assign load     = beat && (state == ODD_ROW) && col[0];

   // Row-phase next state: flips only on the last beat of each row.
   always_comb begin
      state_next = state;
      if (beat && col_last) begin
         state_next = (state == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
      end
   end

   // Row-phase state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EVEN_ROW;
      end else begin
         state <= state_next;
      end
   end

   // Raster position counters; wrap straight into the next frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else if (beat) begin
         if (col_last) begin
            col <= '0;
            row <= row_last ? '0 : row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

   // Left pixel of the current horizontal pair.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold <= '0;
      end else if (beat && !col[0]) begin
         hold <= pix;
      end
   end

   // Line buffer: top-row pair maxima; always written before being read.
   always_ff @(posedge clk) begin
      if (beat && (state == EVEN_ROW) && col[0]) begin
         lbuf[lb_idx] <= pair_max;
      end
   end

   // Output register: load on window completion, otherwise drain on ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= win_max;
         out_last  <= row_last && col_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_max_pool_2x2.sv
`timescale 1ns/1ps
// tb_max_pool_2x2: 4x4 instance for directed and table-driven frames,
// 28x28 instance for a randomised frame against a window-max model.
module tb_max_pool_2x2;

   localparam int W = 32;

`ifdef POOL_RELU_CLAMP_EN
   localparam bit CLAMP = 1'b1;
`else
   localparam bit CLAMP = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] c;
      logic [W-1:0] d;
      logic [W-1:0] exp;
   } vec_t;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic         in_valid4, in_ready4, out_valid4, out_ready4, out_last4;
   logic [W-1:0] in_data4, out_data4;
   logic         in_valid28, in_ready28, out_valid28, out_last28;
   logic         out_ready28 = 1'b1;
   logic [W-1:0] in_data28, out_data28;

   int           total = 0;
   int           bad   = 0;
   logic [W:0]   exp4_q[$];
   logic [W:0]   exp28_q[$];
   logic [W-1:0] frame4 [16];
   logic [W-1:0] exp4   [4];
   logic [W-1:0] img28  [784];
   vec_t         tbl    [9];
   int           out_cnt28  = 0;
   int           last_cnt28 = 0;
   bit           rnd28 = 1'b0;

   max_pool_2x2 #(.IMG_W(4), .IMG_H(4), .INTERNAL_BITS(W)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
      .out_valid(out_valid4), .out_ready(out_ready4),
      .out_data(out_data4), .out_last(out_last4)
   );

   max_pool_2x2 #(.IMG_W(28), .IMG_H(28), .INTERNAL_BITS(W)) dut28 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid28), .in_ready(in_ready28), .in_data(in_data28),
      .out_valid(out_valid28), .out_ready(out_ready28),
      .out_data(out_data28), .out_last(out_last28)
   );

   task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   function automatic logic [W-1:0] clampf(input logic [W-1:0] v);
      return (CLAMP && v[W-1]) ? '0 : v;
   endfunction

   function automatic logic [W-1:0] smax(input logic [W-1:0] a, input logic [W-1:0] b);
      return ($signed(a) > $signed(b)) ? a : b;
   endfunction

   function automatic logic [W-1:0] win_max28(input int r, input int c);
      logic [W-1:0] m;
      m = clampf(img28[(r-1)*28 + c-1]);
      m = smax(m, clampf(img28[(r-1)*28 + c]));
      m = smax(m, clampf(img28[r*28 + c-1]));
      m = smax(m, clampf(img28[r*28 + c]));
      return m;
   endfunction

   // scoreboard, 4x4 instance
   always @(negedge clk) begin
      if (rst_n && out_valid4 && out_ready4) begin
         if (exp4_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexp4: got %h want none", {out_last4, out_data4});
         end else begin
            check("out4", {out_last4, out_data4}, exp4_q.pop_front());
         end
      end
   end

   // scoreboard, 28x28 instance
   always @(negedge clk) begin
      if (rst_n && out_valid28 && out_ready28) begin
         out_cnt28++;
         if (out_last28) last_cnt28++;
         if (exp28_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexp28: got %h want none", {out_last28, out_data28});
         end else begin
            check("out28", {out_last28, out_data28}, exp28_q.pop_front());
         end
      end
   end

   // consumer for the 28x28 instance: random back-pressure when enabled
   always @(posedge clk) begin
      #1;
      out_ready28 = rnd28 ? ($urandom_range(0, 2) != 0) : 1'b1;
   end

   // driver: presents frame4[0..n-1], pushes a window result on its last beat
   task automatic drive4(input int n, output int cycles);
      int k;
      int r;
      int c;
      k = 0;
      cycles = 0;
      while (k < n && cycles < 1000) begin
         @(posedge clk);
         #1;
         in_valid4 = 1'b1;
         in_data4  = frame4[k];
         @(negedge clk);
         cycles++;
         if (in_ready4) begin
            r = k / 4;
            c = k % 4;
            if (r % 2 == 1 && c % 2 == 1) exp4_q.push_back({k == 15, exp4[(r/2)*2 + c/2]});
            k++;
         end
      end
      check("feed4", k, n);
   endtask

   task automatic end4();
      @(posedge clk);
      #1;
      in_valid4 = 1'b0;
   endtask

   task automatic drain4();
      int waited;
      waited = 0;
      while (exp4_q.size() != 0 && waited < 60) begin
         @(negedge clk);
         waited++;
      end
      repeat (3) @(negedge clk);
      check("drain4", exp4_q.size(), 0);
      exp4_q.delete();
   endtask

   task automatic stall5();
      int waited;
      waited = 0;
      while (!out_valid4 && waited < 100) begin
         @(posedge clk);
         #1;
         waited++;
      end
      check("stall_seen", out_valid4, 1);
      out_ready4 = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("stall_hold", {out_last4, out_data4}, {1'b0, 32'd6});
         check("stall_in_ready", in_ready4, 0);
      end
      @(posedge clk);
      #1;
      out_ready4 = 1'b1;
   endtask

   task automatic set_ramp(input int base);
      for (int i = 0; i < 16; i++) frame4[i] = W'(base + i + 1);
      exp4[0] = W'(base + 6);
      exp4[1] = W'(base + 8);
      exp4[2] = W'(base + 14);
      exp4[3] = W'(base + 16);
   endtask

   initial begin
      int cyc;
      int k;
      int r;
      int c;
      int waited;

      tbl[0] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h7FFFFFFF};
      tbl[1] = '{32'hFFFFFFFB, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'hFFFFFFFB,
                 CLAMP ? 32'h0 : 32'hFFFFFFFB};
      tbl[2] = '{32'hFFFFFFFD, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFF7,
                 CLAMP ? 32'h0 : 32'hFFFFFFFF};
      tbl[3] = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd5};
      tbl[4] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
                 CLAMP ? 32'h0 : 32'h80000000};
      tbl[5] = '{32'd4, 32'd1, 32'd2, 32'd3, 32'd4};
      tbl[6] = '{32'd1, 32'd4, 32'd2, 32'd3, 32'd4};
      tbl[7] = '{32'd1, 32'd2, 32'd4, 32'd3, 32'd4};
      tbl[8] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd4};

      rst_n      = 1'b0;
      in_valid4  = 1'b0;
      in_data4   = '0;
      out_ready4 = 1'b1;
      in_valid28 = 1'b0;
      in_data28  = '0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out4", {out_last4, out_valid4, out_data4}, '0);
      check("rst_in_ready4", in_ready4, 1);
      check("rst_valid28", out_valid28, 0);
      check("rst_in_ready28", in_ready28, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // ramp frame, full throughput
      set_ramp(0);
      drive4(16, cyc);
      check("no_stall_cycles", cyc, 16);
      end4();
      drain4();

      // output back-pressure on the first pooled pixel
      set_ramp(0);
      fork
         drive4(16, cyc);
         stall5();
      join
      end4();
      drain4();

      // two frames back to back
      set_ramp(0);
      drive4(16, cyc);
      set_ramp(100);
      drive4(16, cyc);
      end4();
      drain4();

      // table of window patterns, same pattern in all four windows
      for (int i = 0; i < 9; i++) begin
         for (int w = 0; w < 4; w++) begin
            frame4[(w/2)*8 + (w%2)*2]     = tbl[i].a;
            frame4[(w/2)*8 + (w%2)*2 + 1] = tbl[i].b;
            frame4[(w/2)*8 + (w%2)*2 + 4] = tbl[i].c;
            frame4[(w/2)*8 + (w%2)*2 + 5] = tbl[i].d;
            exp4[w] = tbl[i].exp;
         end
         drive4(16, cyc);
         end4();
         drain4();
      end

      // reset in the middle of a frame with a pooled pixel pending
      set_ramp(0);
      out_ready4 = 1'b0;
      drive4(6, cyc);
      @(posedge clk);
      #3;
      check("pend_valid", out_valid4, 1);
      rst_n = 1'b0;
      #1;
      check("async_clear", {out_last4, out_valid4, out_data4}, '0);
      check("async_in_ready", in_ready4, 1);
      exp4_q.delete();
      in_valid4 = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready4 = 1'b1;
      set_ramp(0);
      drive4(16, cyc);
      end4();
      drain4();

      // 28x28 random frame with gaps on both sides
      for (int i = 0; i < 784; i++) begin
         case ($urandom_range(0, 2))
            0:       img28[i] = $urandom;
            1:       img28[i] = W'($urandom_range(0, 20)) - W'(10);
            default: img28[i] = W'($urandom_range(0, 1000));
         endcase
      end
      rnd28 = 1'b1;
      k = 0;
      cyc = 0;
      while (k < 784 && cyc < 20000) begin
         @(posedge clk);
         #1;
         in_valid28 = ($urandom_range(0, 3) != 0);
         in_data28  = img28[k];
         @(negedge clk);
         cyc++;
         if (in_valid28 && in_ready28) begin
            r = k / 28;
            c = k % 28;
            if (r % 2 == 1 && c % 2 == 1) exp28_q.push_back({k == 783, win_max28(r, c)});
            k++;
         end
      end
      check("feed28", k, 784);
      @(posedge clk);
      #1;
      in_valid28 = 1'b0;
      waited = 0;
      while (exp28_q.size() != 0 && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      rnd28 = 1'b0;
      repeat (4) @(negedge clk);
      check("drain28", exp28_q.size(), 0);
      check("count28", out_cnt28, 196);
      check("last28", last_cnt28, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
